mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TAG_DEPTH, default 4, giving the max outstanding reads tracked (power of 2, at least 2).
REQ-002 SHALL have port clock, input, 1 bit: the single clock; all state updates on rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have CPU-side ports: cpu_request in 1, cpu_address in 32, cpu_write in 1, cpu_wstrb in 4, cpu_wdata in 32.
REQ-005 SHALL have CPU-side ports: cpu_rdata out 32, cpu_mem_busy out 1, cpu_valid out 1.
REQ-006 SHALL have DMA-side ports: dma_request in 1, dma_address in 32, dma_write in 1, dma_wstrb in 4, dma_wdata in 32.
REQ-007 SHALL have DMA-side ports: dma_rdata out 32, dma_mem_busy out 1, dma_valid out 1.
REQ-008 SHALL have memory-side outputs: mem_request 1, mem_address 32, mem_write 1, mem_wstrb 4, mem_wdata 32.
REQ-009 SHALL have memory-side inputs: mem_rdata in 32, mem_busy in 1, mem_valid in 1.
REQ-010 SHALL have port arb_error, output, 1 bit: sticky protocol-error flag.

Function
REQ-011 SHALL define a transfer as accepted on a side in the cycle its request=1 and its mem_busy output=0; requesters hold all request fields until accepted.
REQ-012 SHALL define memory acceptance as mem_request=1 and mem_busy=0 in the same cycle.
REQ-013 SHALL select combinationally each cycle: one requester active -> that requester; both active -> the requester named by the 1-bit priority register rr (0=CPU, 1=DMA).
REQ-014 SHALL drive mem_request/address/write/wstrb/wdata from the selected requester; mem_request=0 and other mem outputs = CPU fields when no request.
REQ-015 SHALL block a read request (request=1, write=0) while the tag FIFO is full: mem_request=0 for it, and its busy=1; a pending write from the other side may then be selected.
REQ-016 SHALL assert the busy output of a requester whenever it requests and it is not selected, or mem_busy=1, or REQ-015 applies.
REQ-017 SHALL, on each memory acceptance, set rr to the side NOT served; rr is unchanged in cycles with no acceptance.
REQ-018 SHALL push a 1-bit owner tag (0=CPU, 1=DMA) into an in-order FIFO of TAG_DEPTH entries on each accepted read; writes push nothing.
REQ-019 SHALL, on mem_valid=1 with the FIFO non-empty, pop the head tag and pulse the owner's valid for that same cycle (zero added latency).
REQ-020 SHALL drive cpu_rdata and dma_rdata = mem_rdata at all times; only the valid pulses are routed.
REQ-021 SHALL allow a push and a pop in the same cycle; the count is then unchanged, including when full (the full check uses the pre-pop count, so no read is accepted that cycle).
REQ-022 SHALL, on mem_valid=1 with the FIFO empty, assert no valid, leave the FIFO unchanged and set arb_error=1 until reset.
REQ-023 SHALL wrap the FIFO read/write pointers modulo TAG_DEPTH.
REQ-024 SHALL keep cpu_valid and dma_valid never both 1 in one cycle.

Reset
REQ-025 SHALL, when reset=1 at a clock edge, set rr=0, empty the FIFO (pointers and count 0) and clear arb_error=0.
REQ-026 SHALL drive, during reset, mem_request=0, cpu_mem_busy=1, dma_mem_busy=1, cpu_valid=0, dma_valid=0.
REQ-027 SHALL discard reads in flight when reset is asserted mid-operation; a later mem_valid with no tags sets arb_error per REQ-022.

Verification
REQ-028 SHALL cover contention: both sides request reads at 0x100 (CPU) and 0x200 (DMA), mem_busy=0 -> CPU accepted first, DMA the next cycle, rr=1 after the 1st acceptance and 0 after the 2nd.
REQ-029 SHALL cover in-order return: CPU read then DMA read accepted, then two mem_valid pulses with rdata 0xAAAA0001 and 0xBBBB0002 -> cpu_valid on the 1st pulse, dma_valid on the 2nd, rdata matching.
REQ-030 SHALL cover FIFO full: 4 CPU reads accepted with no mem_valid -> 5th CPU read busy=1 while a DMA write proceeds; 1 mem_valid -> 5th read accepted the following cycle.
REQ-031 SHALL cover backpressure: mem_busy=1 for 3 cycles with a CPU write pending -> cpu_mem_busy=1 for those cycles, fields held, write accepted on the 4th cycle, no tag pushed.
REQ-032 SHALL cover stray response: mem_valid=1 with the FIFO empty -> no valid pulse and arb_error=1 sticky; reset -> arb_error=0.
REQ-033 SHALL cover reset mid-operation: 2 reads outstanding, then reset -> FIFO count 0, rr=0 and all outputs at REQ-026 values.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester (CPU, DMA) arbiter onto a single memory port.
// - Round-robin on contention via a 1-bit priority register (0=CPU, 1=DMA).
// - Read responses return in order; an owner-tag FIFO routes each mem_valid
//   pulse to the requester that issued the read.
// - arb_error is a sticky flag for a mem_valid with no outstanding read.
// Ports:
//   clock, reset                    - single clock, synchronous active-high reset
//   cpu_* / dma_*                   - requester interfaces (request, address, write, wstrb,
//                                     wdata in; rdata, mem_busy, valid out)
//   mem_*                           - memory interface (request fields out; rdata, busy,
//                                     valid in)
//   arb_error                       - sticky protocol-error flag
module mem_arbiter #(
  parameter int unsigned TAG_DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  // CPU side
  input  logic        cpu_request,
  input  logic [31:0] cpu_address,
  input  logic        cpu_write,
  input  logic [3:0]  cpu_wstrb,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_mem_busy,
  output logic        cpu_valid,
  // DMA side
  input  logic        dma_request,
  input  logic [31:0] dma_address,
  input  logic        dma_write,
  input  logic [3:0]  dma_wstrb,
  input  logic [31:0] dma_wdata,
  output logic [31:0] dma_rdata,
  output logic        dma_mem_busy,
  output logic        dma_valid,
  // Memory side
  output logic        mem_request,
  output logic [31:0] mem_address,
  output logic        mem_write,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_busy,
  input  logic        mem_valid,
  // Status
  output logic        arb_error
);

  localparam int unsigned PtrW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;

  logic [TAG_DEPTH-1:0] tags_q;
  logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]      cnt_q;
  logic                 rr_q;
  logic                 err_q;

  logic fifo_full, fifo_empty;
  logic cpu_elig, dma_elig;
  logic sel_dma, cpu_sel;
  logic accept, push, pop, head_tag;

  // Full check uses the pre-pop count, so a same-cycle pop never frees a slot early.
  assign fifo_full  = (cnt_q == CntW'(TAG_DEPTH));
  assign fifo_empty = (cnt_q == '0);

  // A read is ineligible while the tag FIFO is full; nothing is eligible in reset.
  assign cpu_elig = ~reset & cpu_request & ~(~cpu_write & fifo_full);
  assign dma_elig = ~reset & dma_request & ~(~dma_write & fifo_full);

  // DMA wins when it is the only eligible side, or on contention when rr points at it.
  assign sel_dma = dma_elig & (~cpu_elig | rr_q);
  assign cpu_sel = cpu_elig & ~sel_dma;

  assign accept   = mem_request & ~mem_busy;
  assign push     = accept & ~mem_write;
  assign pop      = ~reset & mem_valid & ~fifo_empty;
  assign head_tag = tags_q[rd_ptr_q];

  always_comb begin
    mem_request = cpu_elig | dma_elig;
    mem_address = sel_dma ? dma_address : cpu_address;
    mem_write   = sel_dma ? dma_write   : cpu_write;
    mem_wstrb   = sel_dma ? dma_wstrb   : cpu_wstrb;
    mem_wdata   = sel_dma ? dma_wdata   : cpu_wdata;

    cpu_mem_busy = reset | (cpu_request & (~cpu_sel | mem_busy));
    dma_mem_busy = reset | (dma_request & (~sel_dma | mem_busy));

    cpu_valid = pop & ~head_tag;
    dma_valid = pop & head_tag;

    cpu_rdata = mem_rdata;
    dma_rdata = mem_rdata;
    arb_error = err_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tags_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      rr_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (push) begin
        tags_q[wr_ptr_q] <= sel_dma;
        wr_ptr_q         <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      if (push && !pop) begin
        cnt_q <= cnt_q + CntW'(1);
      end else if (pop && !push) begin
        cnt_q <= cnt_q - CntW'(1);
      end
      // Next contention goes to the side that was not just served.
      if (accept) begin
        rr_q <= ~sel_dma;
      end
      if (mem_valid && fifo_empty) begin
        err_q <= 1'b1;
      end
    end
  end

endmodule
